// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the pipelined Wishbone RAM.
//   RamMaxLatency   - deepest supported response pipeline.
//   RamMaxDataWidth - widest supported data word; the response struct carries
//                     a field this wide and narrower instances use the low bits.
//   ram_resp_t      - one response pipeline stage: {valid, err, data}.
package ram_pkg;

  localparam int RamMaxLatency   = 4;
  localparam int RamMaxDataWidth = 64;

  typedef struct packed {
    logic                       valid;
    logic                       err;
    logic [RamMaxDataWidth-1:0] data;
  } ram_resp_t;

endpackage

// File: rtl/ram_pipelined_if.sv
// ram_pipelined_if: Wishbone B4 pipelined bus between a master and the RAM.
//   master -> slave: bus_cyc, bus_stb, bus_we, bus_addr, bus_sel, bus_data_m
//   slave -> master: bus_ack, bus_err, bus_stall, bus_data_s
//
// Handshake: a request transfers on every rising edge where
// bus_cyc & bus_stb & ~bus_stall. Each transfer gets exactly one response,
// either bus_ack or bus_err (never both), unless the master drops bus_cyc
// first, which abandons every outstanding response. bus_data_s is only
// meaningful while bus_ack is high.
interface ram_pipelined_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 16
);
  localparam int SelWidth = DataWidth / 8;

  logic [DataWidth-1:0] bus_data_s;
  logic                 bus_ack;
  logic                 bus_stall;
  logic                 bus_err;
  logic [DataWidth-1:0] bus_data_m;
  logic [AddrWidth-1:0] bus_addr;
  logic [SelWidth-1:0]  bus_sel;
  logic                 bus_cyc;
  logic                 bus_stb;
  logic                 bus_we;

  modport master (
    output bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
    input  bus_data_s, bus_ack, bus_stall, bus_err
  );

  modport slave (
    input  bus_data_m, bus_addr, bus_sel, bus_cyc, bus_stb, bus_we,
    output bus_data_s, bus_ack, bus_stall, bus_err
  );
endinterface

// File: rtl/ram_resp_pipe.sv
// ram_resp_pipe: Latency-deep shift register of responses.
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, empties every stage
//   flush    - synchronous flush, empties every stage (master dropped cyc)
//   resp_in  - response generated at the accept edge
//   resp_out - oldest stage; drives the bus outputs directly
module ram_resp_pipe
  import ram_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  ram_resp_t resp_in,
  output ram_resp_t resp_out
);

  ram_resp_t stage [Latency];

  // Cleared stages carry zero data as well as valid=0, so the bus data
  // output is zero whenever no ack is presented.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < Latency; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= resp_in;
      for (int i = 1; i < Latency; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign resp_out = stage[Latency-1];

endmodule

// File: rtl/ram_pipelined.sv
// ram_pipelined: parametrised single-port RAM, Wishbone B4 pipelined slave.
//   clk - clock, rising edge
//   rst - synchronous active-high reset of the response path (memory kept)
//   bus - ram_pipelined_if.slave: never stalls; ack/err Latency cycles after
//         each accepted request; out-of-range words answer with err.
// Parameters: Depth (words, any value up to 2^AddrWidth), DataWidth (multiple
// of 8, at most RamMaxDataWidth), AddrWidth, Latency (1..RamMaxLatency).
module ram_pipelined
  import ram_pkg::*;
#(
  parameter int Depth     = 1024,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 16,
  parameter int Latency   = 1
) (
  input  logic             clk,
  input  logic             rst,
  ram_pipelined_if.slave   bus
);

  localparam int SelWidth = DataWidth / 8;
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem [Depth];

  logic                 accept;
  logic                 in_range;
  logic                 flush;
  logic [IdxWidth-1:0]  idx;
  logic [DataWidth-1:0] rd_word;
  ram_resp_t            resp_in;
  ram_resp_t            resp_out;
  logic                 unused_data_hi;

  assign accept = bus.bus_cyc & bus.bus_stb;
  assign flush  = ~bus.bus_cyc;
  // One extra bit so Depth == 2^AddrWidth is representable.
  assign in_range = {1'b0, bus.bus_addr} < (AddrWidth + 1)'(Depth);
  assign idx      = bus.bus_addr[IdxWidth-1:0];

  // Byte-lane writes; reset wins over a coincident strobe.
  always_ff @(posedge clk) begin
    if (!rst && accept && in_range && bus.bus_we) begin
      for (int i = 0; i < SelWidth; i++) begin
        if (bus.bus_sel[i]) begin
          mem[idx][8*i +: 8] <= bus.bus_data_m[8*i +: 8];
        end
      end
    end
  end

  // Read value is captured into the pipeline at the accept edge, so it sees
  // every write committed on earlier edges.
  always_comb begin
    rd_word = '0;
    if (in_range) begin
      rd_word = mem[idx];
    end
  end

  always_comb begin
    resp_in       = '0;
    resp_in.valid = accept;
    resp_in.err   = accept & ~in_range;
    if (accept && in_range && !bus.bus_we) begin
      resp_in.data = RamMaxDataWidth'(rd_word);
    end
  end

  ram_resp_pipe #(
    .Latency (Latency)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .resp_in  (resp_in),
    .resp_out (resp_out)
  );

  // Outputs come straight from the last pipeline register.
  assign bus.bus_ack    = resp_out.valid & ~resp_out.err;
  assign bus.bus_err    = resp_out.valid & resp_out.err;
  assign bus.bus_data_s = resp_out.data[DataWidth-1:0];
  assign bus.bus_stall  = 1'b0;

  // Upper data bits of the shared struct are unused for narrow words.
  assign unused_data_hi = ^resp_out.data;

endmodule

// File: tb/tb_ram_pipelined.sv
`timescale 1ns/1ps
module tb_ram_pipelined;
  import ram_pkg::*;

  localparam int NI = 3;   // u0: L=1 D=16 A=16, u1: L=3 D=10 A=4, u2: L=4 D=10 A=4
  localparam int NS = 24;  // slots per scenario window

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared master-side stimulus, fanned out to all three instances.
  logic        cyc, stb, we;
  logic [15:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;

  ram_pipelined_if #(.DataWidth(32), .AddrWidth(16)) bus0 ();
  ram_pipelined_if #(.DataWidth(32), .AddrWidth(4))  bus1 ();
  ram_pipelined_if #(.DataWidth(32), .AddrWidth(4))  bus2 ();

  assign bus0.bus_cyc = cyc;  assign bus1.bus_cyc = cyc;  assign bus2.bus_cyc = cyc;
  assign bus0.bus_stb = stb;  assign bus1.bus_stb = stb;  assign bus2.bus_stb = stb;
  assign bus0.bus_we  = we;   assign bus1.bus_we  = we;   assign bus2.bus_we  = we;
  assign bus0.bus_sel = sel;  assign bus1.bus_sel = sel;  assign bus2.bus_sel = sel;
  assign bus0.bus_data_m = wdata;
  assign bus1.bus_data_m = wdata;
  assign bus2.bus_data_m = wdata;
  assign bus0.bus_addr = addr;
  assign bus1.bus_addr = addr[3:0];
  assign bus2.bus_addr = addr[3:0];

  ram_pipelined #(.Depth(16), .DataWidth(32), .AddrWidth(16), .Latency(1))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  ram_pipelined #(.Depth(10), .DataWidth(32), .AddrWidth(4), .Latency(3))
    u1 (.clk(clk), .rst(rst), .bus(bus1));
  ram_pipelined #(.Depth(10), .DataWidth(32), .AddrWidth(4), .Latency(4))
    u2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        o_ack [NI];
  logic        o_err [NI];
  logic        o_stall [NI];
  logic [31:0] o_data [NI];
  assign o_ack[0] = bus0.bus_ack;   assign o_err[0] = bus0.bus_err;
  assign o_ack[1] = bus1.bus_ack;   assign o_err[1] = bus1.bus_err;
  assign o_ack[2] = bus2.bus_ack;   assign o_err[2] = bus2.bus_err;
  assign o_stall[0] = bus0.bus_stall;
  assign o_stall[1] = bus1.bus_stall;
  assign o_stall[2] = bus2.bus_stall;
  assign o_data[0] = bus0.bus_data_s;
  assign o_data[1] = bus1.bus_data_s;
  assign o_data[2] = bus2.bus_data_s;

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus tables ----------------
  logic        t_rst [NS];
  logic        t_cyc [NS];
  logic        t_stb [NS];
  logic        t_we  [NS];
  logic [15:0] t_addr [NS];
  logic [3:0]  t_sel [NS];
  logic [31:0] t_wdat [NS];
  // Expected response per instance for the request in slot j:
  // 0 = none (or flushed), 1 = ack, 2 = err.
  int          e_kind [NI][NS];
  logic [31:0] e_data [NI][NS];

  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // Expected {ack, err, stall, data} seen after edge j for instance k.
  function automatic logic [34:0] exp_vec(int k, int j);
    int a;
    logic ea, ee;
    logic [31:0] ed;
    a  = j - lat_of(k) + 1;
    ea = 1'b0; ee = 1'b0; ed = '0;
    if (a >= 0 && a < NS) begin
      ea = (e_kind[k][a] == 1);
      ee = (e_kind[k][a] == 2);
      ed = e_data[k][a];
    end
    return {ea, ee, 1'b0, ed};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_tables();
    for (int j = 0; j < NS; j++) begin
      t_rst[j] = 1'b0; t_cyc[j] = 1'b1; t_stb[j] = 1'b0; t_we[j] = 1'b0;
      t_addr[j] = '0;  t_sel[j] = '0;   t_wdat[j] = '0;
      for (int k = 0; k < NI; k++) begin
        e_kind[k][j] = 0;
        e_data[k][j] = '0;
      end
    end
  endtask

  task automatic set_req(int j, logic w, logic [15:0] a, logic [3:0] s, logic [31:0] d);
    t_stb[j] = 1'b1; t_we[j] = w; t_addr[j] = a; t_sel[j] = s; t_wdat[j] = d;
  endtask

  task automatic set_exp(int k, int j, int kind, logic [31:0] d);
    e_kind[k][j] = kind;
    e_data[k][j] = d;
  endtask

  task automatic set_exp_all(int j, int kind, logic [31:0] d);
    for (int k = 0; k < NI; k++) set_exp(k, j, kind, d);
  endtask

  // Apply slot j before the next rising edge; return at the falling edge.
  task automatic drive_slot(int j);
    rst = t_rst[j]; cyc = t_cyc[j]; stb = t_stb[j]; we = t_we[j];
    addr = t_addr[j]; sel = t_sel[j]; wdata = t_wdat[j];
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; sel = '0; wdata = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== 35'd0) begin
        errors++;
        $display("FAIL reset u%0d: got ack=%b err=%b stall=%b data=%h, want all 0",
                 k, o_ack[k], o_err[k], o_stall[k], o_data[k]);
      end
    end
  endtask

  task automatic test_write_read();
    clear_tables();
    set_req(0, 1'b1, 16'd3, 4'hF, 32'hDEADBEEF);
    set_req(1, 1'b0, 16'd3, 4'h0, 32'h0);
    set_exp_all(0, 1, 32'h0);
    set_exp_all(1, 1, 32'hDEADBEEF);
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL write_read u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    clear_tables();
    set_req(0, 1'b1, 16'd5, 4'hF,    32'h11223344);
    set_req(1, 1'b1, 16'd5, 4'b0101, 32'hAABBCCDD);
    set_req(2, 1'b0, 16'd5, 4'h0,    32'h0);
    set_exp_all(0, 1, 32'h0);
    set_exp_all(1, 1, 32'h0);
    set_exp_all(2, 1, 32'h11BB33DD);
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL byte_lanes u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_tables();
    for (int i = 0; i < 4; i++) begin
      set_req(i,     1'b1, 16'(i), 4'hF, 32'(i));
      set_req(i + 4, 1'b0, 16'(i), 4'h0, 32'h0);
      set_exp_all(i,     1, 32'h0);
      set_exp_all(i + 4, 1, 32'(i));
    end
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL back_to_back u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  // Addr 12 is in range for u0 (Depth 16) and out of range for u1/u2 (Depth 10).
  task automatic test_out_of_range();
    clear_tables();
    for (int i = 0; i < 6; i++) begin
      set_req(i, 1'b1, 16'(4 + i), 4'hF, 32'h44 + 32'(i));
      set_exp_all(i, 1, 32'h0);
    end
    set_req(6, 1'b1, 16'd12, 4'hF, 32'hFFFFFFFF);
    set_req(7, 1'b0, 16'd12, 4'h0, 32'h0);
    set_exp(0, 6, 1, 32'h0);
    set_exp(0, 7, 1, 32'hFFFFFFFF);
    for (int k = 1; k < NI; k++) begin
      set_exp(k, 6, 2, 32'h0);
      set_exp(k, 7, 2, 32'h0);
    end
    for (int i = 0; i < 10; i++) begin
      set_req(8 + i, 1'b0, 16'(i), 4'h0, 32'h0);
      set_exp_all(8 + i, 1, (i < 4) ? 32'(i) : 32'h40 + 32'(i));
    end
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL out_of_range u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  // Write then read addr 7, drop cyc in slot 3: u2 (L=4) loses both
  // responses, u1 (L=3) keeps only the write ack, u0 keeps both.
  task automatic test_flush();
    clear_tables();
    set_req(0, 1'b1, 16'd7, 4'hF, 32'h77777777);
    set_req(1, 1'b0, 16'd7, 4'h0, 32'h0);
    t_cyc[3] = 1'b0;
    set_req(5, 1'b0, 16'd7, 4'h0, 32'h0);
    set_exp(0, 0, 1, 32'h0);
    set_exp(0, 1, 1, 32'h77777777);
    set_exp(1, 0, 1, 32'h0);
    set_exp_all(5, 1, 32'h77777777);
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL flush u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  // Read in flight, then rst together with a write strobe to the same word.
  task automatic test_reset_inflight();
    clear_tables();
    set_req(0, 1'b0, 16'd7, 4'h0, 32'h0);
    t_rst[1] = 1'b1;
    set_req(1, 1'b1, 16'd7, 4'hF, 32'h12345678);
    set_req(3, 1'b0, 16'd7, 4'h0, 32'h0);
    set_exp(0, 0, 1, 32'h77777777);
    set_exp_all(3, 1, 32'h77777777);
    for (int j = 0; j < NS; j++) begin
      drive_slot(j);
      for (int k = 0; k < NI; k++) begin
        logic [34:0] ev;
        ev = exp_vec(k, j);
        checks++;
        if ({o_ack[k], o_err[k], o_stall[k], o_data[k]} !== ev) begin
          errors++;
          $display("FAIL reset_inflight u%0d s%0d: got ack=%b err=%b stall=%b data=%h, want ack=%b err=%b stall=0 data=%h",
                   k, j, o_ack[k], o_err[k], o_stall[k], o_data[k], ev[34], ev[33], ev[31:0]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_flush();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_pipelined.md
# ram_pipelined

Parametrised Wishbone-pipelined (B4 pipelined mode) single-port RAM slave, next generation of the fixed 32-bit, 1-cycle RAM. Adds configurable data width, explicit address width with out-of-range error response, configurable read/ack latency via a response pipeline, synchronous reset of all bus outputs, and flushing of in-flight responses when the master drops `bus_cyc`. Sits on the system bus behind the interconnect as instruction/data memory.

## Interface

- `Depth`, 1024: number of words; need not be a power of two; must satisfy 1 ≤ Depth ≤ 2^AddrWidth.
- `DataWidth`, 32: word width in bits; multiple of 8.
- `AddrWidth`, 16: word-address width.
- `Latency`, 1: cycles from accepted request to `bus_ack`/`bus_err`; legal range 1..4.
- `SelWidth`, DataWidth/8: localparam, byte-lane count.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_data_s`  out  DataWidth  read data; valid only with `bus_ack`, else 0.
- `bus_ack`  out  1  normal termination, one cycle per accepted request.
- `bus_stall`  out  1  tied 0; every strobe is accepted.
- `bus_err`  out  1  error termination for out-of-range address.
- `bus_data_m`  in  DataWidth  write data.
- `bus_addr`  in  AddrWidth  word address.
- `bus_sel`  in  SelWidth  byte-lane enables for writes; ignored for reads.
- `bus_cyc`  in  1  cycle valid.
- `bus_stb`  in  1  request strobe.
- `bus_we`  in  1  1 = write, 0 = read.

## Operation

- Accept = `bus_cyc & bus_stb` (stall is 0). Exactly one response per accept, unless flushed.
- In range (`bus_addr < Depth`):
  - write: lanes with `bus_sel[i]=1` written at the accept edge; other lanes unchanged; response is ack with data 0.
  - read: memory sampled at the accept edge, after any earlier-cycle write; response is ack with that word.
- Out of range: no memory access; response is `bus_err=1`, `bus_ack=0`, data 0.
- `bus_ack` and `bus_err` are never both 1.
- Response pipeline of `Latency` stages, each holding {valid, err, data}; advances every cycle.
- Flush: whenever `bus_cyc=0`, all stages are invalidated at that edge. Writes already accepted stay committed. A request presented with `bus_cyc=1` in the same cycle as a flush is not possible, since flush implies cyc=0.
- Reset: all stages invalid; `bus_ack=0`, `bus_err=0`, `bus_data_s=0`, `bus_stall=0`. Memory contents are not cleared. `rst` coincident with a strobe: reset wins, no write, no response.

## Timing

- Accept at edge n → `bus_ack`/`bus_err` high during the cycle after edge n+Latency-1.
  - Latency=1 gives the same timing as the previous RAM: ack the cycle after the strobe.
- Back-to-back strobes give back-to-back responses; throughput is 1 per cycle for every `Latency`.
- Read-after-write to the same address, in consecutive cycles, returns the new data.
- Write and read in the same cycle cannot occur (single port, one request per cycle).
- `bus_cyc` deasserted at cycle k: no `bus_ack`/`bus_err` from cycle k+1 onward for requests accepted before k.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure

- `ram_pkg`:
  - `ram_resp_t` packed struct {valid, err, data}, parameterised by width through a localparam or a max-width field.
  - constant `RamMaxLatency = 4`.
- Sub-module `ram_resp_pipe`: `Latency`-deep shift register of `ram_resp_t` with synchronous flush and reset. The top level holds the memory array, the address range check and the byte-lane writes.

## Test plan

- Latency=1, Depth=16: write 0xDEADBEEF to addr 3 with sel=4'hF, then read addr 3 → ack one cycle after each strobe; read returns 0xDEADBEEF.
- Byte lanes: pre-load 0x11223344 at addr 5; write 0xAABBCCDD with sel=4'b0101 → read returns 0x11BB33DD.
- Latency=3: four back-to-back reads of addrs 0..3 holding 0,1,2,3 → acks on four consecutive cycles starting 3 cycles after the first strobe, data 0,1,2,3 in order.
- Depth=10, AddrWidth=4: read addr 12 → `bus_err=1`, `bus_ack=0`, data 0 after Latency cycles; write addr 12 leaves addrs 0..9 unchanged.
- Latency=4: issue a write then a read, drop `bus_cyc` 2 cycles later → no ack/err appears afterwards; a subsequent read shows the write committed.
- Assert `rst` with one response in flight and a simultaneous write strobe → outputs 0 the next cycle; no ack; target word unchanged.
